// File: rtl/spm_bcd_converter.sv
// Captures the signed product on a rising start edge and converts its magnitude to packed BCD, one bit per clock.
// Result appears WIDTH clocks after the accepting edge; start edges while busy are dropped, never queued.
module spm_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  R,
   input  logic                  start,
   input  logic [WIDTH-1:0]      P_in,
   output logic                  busy,
   output logic                  valid,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t                 state_q;
   logic                   start_prev_q;
   logic [SW-1:0]          step_q;
   logic [WIDTH-1:0]       mag_q;
   logic [WIDTH-1:0]       mag_d;
   logic [WIDTH-1:0]       mag_in;
   logic [4*DIGITS-1:0]    scratch_q;
   logic [4*DIGITS-1:0]    scratch_d;
   logic [4*DIGITS-1:0]    adj;
   logic                   sign_int_q;
   logic                   busy_q;
   logic                   valid_q;
   logic                   sign_q;
   logic [4*DIGITS-1:0]    bcd_q;
   logic                   accept;

   assign accept = start & ~start_prev_q & (state_q != SHIFT);

   // Unsigned magnitude: the most negative value maps onto itself, which reads correctly as unsigned.
   assign mag_in = P_in[WIDTH-1] ? (~P_in + WIDTH'(1)) : P_in;

   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
      {scratch_d, mag_d} = {adj, mag_q} << 1;
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b0;
         step_q       <= '0;
         mag_q        <= '0;
         scratch_q    <= '0;
         sign_int_q   <= 1'b0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         sign_q       <= 1'b0;
         bcd_q        <= '0;
      end else begin
         start_prev_q <= start;
         if (accept) begin
            state_q    <= SHIFT;
            mag_q      <= mag_in;
            sign_int_q <= P_in[WIDTH-1];
            scratch_q  <= '0;
            step_q     <= '0;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
         end else if (state_q == SHIFT) begin
            scratch_q <= scratch_d;
            mag_q     <= mag_d;
            step_q    <= step_q + SW'(1);
            // Published outputs only change here, so partial digits are never visible.
            if (step_q == SW'(WIDTH-1)) begin
               bcd_q   <= scratch_d;
               sign_q  <= sign_int_q;
               busy_q  <= 1'b0;
               valid_q <= 1'b1;
               state_q <= HOLD;
            end
         end
      end
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign sign  = sign_q;
   assign bcd   = bcd_q;

endmodule

// File: tb/tb_spm_bcd_converter.sv
// Directed bench for spm_bcd_converter: hand-computed sign/BCD results, busy length, ignored edges, reset abort.
module tb_spm_bcd_converter;

   logic        clk;
   logic        R;
   logic        start;
   logic [15:0] P_in;
   logic        busy;
   logic        valid;
   logic        sign;
   logic [19:0] bcd;

   int          total = 0;
   int          bad   = 0;
   logic        prev_sign;
   logic [19:0] prev_bcd;

   spm_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
      .clk   (clk),
      .R     (R),
      .start (start),
      .P_in  (P_in),
      .busy  (busy),
      .valid (valid),
      .sign  (sign),
      .bcd   (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Raise start with p, scramble P_in after acceptance, count busy cycles and check the result.
   task automatic conv(input string tag, input logic [15:0] p, input logic es, input logic [19:0] eb,
                       input logic rel, input int glitch_at, input logic [15:0] gp);
      int n;
      @(negedge clk);
      if (rel) R = 1'b1;
      start = 1'b1;
      P_in  = p;
      @(negedge clk);
      P_in = ~p;
      chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (n == 8) begin
            chk({tag, "_mid_valid"}, 32'(valid), 32'd0);
            chk({tag, "_mid_bcd"}, 32'(bcd), 32'(prev_bcd));
            chk({tag, "_mid_sign"}, 32'(sign), 32'(prev_sign));
         end
         if (glitch_at != 0 && n == glitch_at - 2) start = 1'b0;
         if (glitch_at != 0 && n == glitch_at) begin
            start = 1'b1;
            P_in  = gp;
         end
         @(negedge clk);
      end
      chk({tag, "_busy_len"}, 32'(n), 32'd16);
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_sign"}, 32'(sign), 32'(es));
      chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
      start     = 1'b0;
      prev_sign = es;
      prev_bcd  = eb;
   endtask

   initial begin
      int n;
      R = 1'b0;
      start = 1'b1;
      P_in = 16'h4000;
      prev_sign = 1'b0;
      prev_bcd = 20'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_sign", 32'(sign), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);

      // start already high when reset releases counts as an edge
      conv("p4000", 16'h4000, 1'b0, 20'h16384, 1'b1, 0, 16'h0);
      conv("pC000", 16'hC000, 1'b1, 20'h16384, 1'b0, 0, 16'h0);
      conv("p8000", 16'h8000, 1'b1, 20'h32768, 1'b0, 0, 16'h0);
      conv("pFFFF", 16'hFFFF, 1'b1, 20'h00001, 1'b0, 0, 16'h0);
      conv("p0000", 16'h0000, 1'b0, 20'h00000, 1'b0, 0, 16'h0);
      conv("p7FFF", 16'h7FFF, 1'b0, 20'h32767, 1'b0, 0, 16'h0);
      conv("m128x128", 16'h4000, 1'b0, 20'h16384, 1'b0, 0, 16'h0);
      conv("m7x9", 16'hFFC1, 1'b1, 20'h00063, 1'b0, 0, 16'h0);

      // second edge 5 clocks in with new operand must be ignored
      conv("glitch", 16'h1234, 1'b0, 20'h04660, 1'b0, 5, 16'h0999);

      // start held high: exactly one conversion
      @(negedge clk);
      start = 1'b1;
      P_in = 16'h0064;
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy) n++;
      end
      chk("held_busy_len", 32'(n), 32'd16);
      chk("held_valid", 32'(valid), 32'd1);
      chk("held_sign", 32'(sign), 32'd0);
      chk("held_bcd", 32'(bcd), 32'h00100);
      start = 1'b0;
      prev_sign = 1'b0;
      prev_bcd = 20'h00100;

      // reset at step 8 discards everything
      @(negedge clk);
      start = 1'b1;
      P_in = 16'h2222;
      repeat (8) @(negedge clk);
      chk("abort_busy_pre", 32'(busy), 32'd1);
      R = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_sign", 32'(sign), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'd0);
      prev_sign = 1'b0;
      prev_bcd = 20'h0;
      conv("after_rst", 16'h0457, 1'b0, 20'h01111, 1'b1, 0, 16'h0);

      repeat (3) @(negedge clk);
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_bcd", 32'(bcd), 32'h01111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
